// File: rtl/aska_spi_regfile.sv
`default_nettype none
// ============================================================================
// Module      : aska_spi_regfile
// Description : SPI mode-0 slave register file, oversampled by the system clock.
// Revision    : 1.0 - initial release
// ============================================================================

module aska_spi_regfile #(
    parameter int                ADDR_W  = 2,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             SPI_CS,
    input  logic                             SPI_Clk,
    input  logic                             SPI_MOSI,
    output logic                             SPI_MISO,
    output logic                             SPI_MISO_oe,
    output logic [(2**ADDR_W)*DATA_W-1:0]    regs,
    output logic                             wr_strobe,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic                             frame_err
);

    localparam int         C_NREG    = 2**ADDR_W;
    localparam int         C_FL      = 8 + DATA_W;
    localparam logic [6:0] C_FL_CNT  = 7'(C_FL);
    localparam logic [6:0] C_OVF_CNT = 7'(C_FL + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_OVF  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronizers and registered edge pulses
    // ------------------------------------------------------------------------
    logic cs_meta_q,   cs_meta_d,   cs_sync_q,   cs_sync_d,   cs_prev_q,   cs_prev_d;
    logic sck_meta_q,  sck_meta_d,  sck_sync_q,  sck_sync_d,  sck_prev_q,  sck_prev_d;
    logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d, mosi_algn_q, mosi_algn_d;
    logic cs_rise_q,   cs_rise_d,   cs_fall_q,   cs_fall_d;
    logic sck_rise_q,  sck_rise_d,  sck_fall_q,  sck_fall_d;

    always_comb begin
        cs_meta_d   = SPI_CS;
        cs_sync_d   = cs_meta_q;
        cs_prev_d   = cs_sync_q;
        sck_meta_d  = SPI_Clk;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        mosi_meta_d = SPI_MOSI;
        mosi_sync_d = mosi_meta_q;
        // MOSI gets one extra stage so it lines up with the registered clock edge
        mosi_algn_d = mosi_sync_q;
        cs_rise_d   =  cs_sync_q  & ~cs_prev_q;
        cs_fall_d   = ~cs_sync_q  &  cs_prev_q;
        sck_rise_d  =  sck_sync_q & ~sck_prev_q;
        sck_fall_d  = ~sck_sync_q &  sck_prev_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            mosi_algn_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
        end else begin
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            mosi_algn_q <= mosi_algn_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            sck_rise_q  <= sck_rise_d;
            sck_fall_q  <= sck_fall_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM, register file and serial transmit path
    // ------------------------------------------------------------------------
    state_t              state_q;
    logic [6:0]          cnt_q;
    logic [7:0]          cmd_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   tx_q;
    logic                rd_act_q;
    logic                miso_q;
    logic                oe_q;
    logic                wr_strobe_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                frame_err_q;
    logic [DATA_W-1:0]   regs_q [C_NREG];

    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   rd_addr;

    always_comb begin
        cmd_addr = cmd_q[ADDR_W-1:0];
        // Address as it will look once the 8th command bit has been shifted in
        rd_addr  = ADDR_W'({cmd_q[6:0], mosi_algn_q});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rd_act_q    <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < C_NREG; k++) begin
                regs_q[k] <= RST_VAL;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (cs_rise_q) begin
                // CS rise outranks a coincident clock edge, which is dropped
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                rd_act_q <= 1'b0;
                oe_q     <= 1'b0;
                miso_q   <= 1'b0;
                if (cnt_q == C_FL_CNT) begin
                    if (cmd_q[7]) begin
                        regs_q[cmd_addr] <= rx_q;
                        wr_strobe_q      <= 1'b1;
                        wr_addr_q        <= cmd_addr;
                    end
                end else if (cnt_q != 7'd0) begin
                    frame_err_q <= 1'b1;
                end
            end else if (cs_fall_q) begin
                state_q  <= S_CMD;
                cnt_q    <= '0;
                rd_act_q <= 1'b0;
            end else if (!cs_prev_q) begin
                if (sck_rise_q && (state_q != S_IDLE)) begin
                    if (cnt_q != C_OVF_CNT) begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                    case (state_q)
                        S_CMD: begin
                            cmd_q <= {cmd_q[6:0], mosi_algn_q};
                            if (cnt_q == 7'd7) begin
                                state_q <= S_DATA;
                                if (!cmd_q[6]) begin
                                    tx_q     <= regs_q[rd_addr];
                                    rd_act_q <= 1'b1;
                                end
                            end
                        end
                        S_DATA: begin
                            rx_q <= {rx_q[DATA_W-2:0], mosi_algn_q};
                            if (cnt_q == C_FL_CNT) begin
                                state_q <= S_OVF;
                            end
                        end
                        default: begin
                        end
                    endcase
                end else if (sck_fall_q && rd_act_q) begin
                    oe_q   <= 1'b1;
                    miso_q <= tx_q[DATA_W-1];
                    tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    for (genvar k = 0; k < C_NREG; k++) begin : g_flat
        assign regs[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_oe = oe_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_aska_spi_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_aska_spi_regfile
// Description : Directed scoreboard bench for two aska_spi_regfile configurations.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_aska_spi_regfile;

    localparam int HP = 6;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         cs0 = 1'b1;
    logic         cs1 = 1'b1;
    logic         sck = 1'b0;
    logic         mosi = 1'b0;

    logic         miso0, oe0, ws0, fe0;
    logic [1:0]   wa0;
    logic [127:0] regs0;
    logic         miso1, oe1, ws1, fe1;
    logic [2:0]   wa1;
    logic [127:0] regs1;

    int checks = 0;
    int errors = 0;
    int ws_cnt0 = 0, ws_cnt1 = 0, fe_cnt0 = 0, fe_cnt1 = 0;

    int          sb_a0[$];
    logic [63:0] sb_d0[$];
    int          sb_a1[$];
    logic [63:0] sb_d1[$];
    logic [31:0] exp0 [4];

    aska_spi_regfile u_dut0 (
        .clk(clk), .resetn(resetn), .SPI_CS(cs0), .SPI_Clk(sck), .SPI_MOSI(mosi),
        .SPI_MISO(miso0), .SPI_MISO_oe(oe0), .regs(regs0), .wr_strobe(ws0),
        .wr_addr(wa0), .frame_err(fe0)
    );

    aska_spi_regfile #(.ADDR_W(3), .DATA_W(16), .RST_VAL(16'hA5A5)) u_dut1 (
        .clk(clk), .resetn(resetn), .SPI_CS(cs1), .SPI_Clk(sck), .SPI_MOSI(mosi),
        .SPI_MISO(miso1), .SPI_MISO_oe(oe1), .regs(regs1), .wr_strobe(ws1),
        .wr_addr(wa1), .frame_err(fe1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs0(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_reg%0d", tag, k), {32'h0, regs0[k*32 +: 32]}, {32'h0, exp0[k]});
        end
    endtask

    // Scoreboard consumers: every write strobe must match the oldest queued write
    always @(negedge clk) begin
        if (ws0) begin
            ws_cnt0++;
            chk("sb0_pending", {63'h0, sb_a0.size() != 0}, 64'h1);
            if (sb_a0.size() != 0) begin
                int a;
                logic [63:0] d;
                a = sb_a0.pop_front();
                d = sb_d0.pop_front();
                chk("sb0_wr_addr", {62'h0, wa0}, 64'(a));
                chk("sb0_wr_data", {32'h0, regs0[a*32 +: 32]}, d);
            end
        end
        if (ws1) begin
            ws_cnt1++;
            chk("sb1_pending", {63'h0, sb_a1.size() != 0}, 64'h1);
            if (sb_a1.size() != 0) begin
                int a;
                logic [63:0] d;
                a = sb_a1.pop_front();
                d = sb_d1.pop_front();
                chk("sb1_wr_addr", {61'h0, wa1}, 64'(a));
                chk("sb1_wr_data", {48'h0, regs1[a*16 +: 16]}, d);
            end
        end
        if (fe0) fe_cnt0++;
        if (fe1) fe_cnt1++;
    end

    task automatic spi_frame(input int sel, input logic [7:0] cmd, input logic [63:0] data,
                             input int dw, input int nbits, input int abort_at,
                             output logic [63:0] rx, output int oe_hi, output int oe_early,
                             output int miso_bad, output logic ws_n2, output logic ws_n3,
                             output logic fe_n2, output logic fe_n3);
        logic cur_oe, cur_miso;
        rx = '0;
        oe_hi = 0;
        oe_early = 0;
        miso_bad = 0;
        @(posedge clk);
        #1;
        if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
        repeat (HP) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                resetn = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_wr_strobe", {63'h0, ws0}, 64'h0);
                chk("rst_wr_addr", {62'h0, wa0}, 64'h0);
                chk("rst_frame_err", {63'h0, fe0}, 64'h0);
                chk("rst_miso", {62'h0, oe0, miso0}, 64'h0);
                for (int k = 0; k < 4; k++) exp0[k] = 32'h0;
                check_regs0("rst");
                resetn = 1'b1;
                break;
            end
            #1;
            if (i < 8) mosi = cmd[7-i];
            else if (i - 8 < dw) mosi = data[dw-1-(i-8)];
            else mosi = 1'b0;
            repeat (HP) @(posedge clk);
            #1;
            cur_oe   = (sel == 0) ? oe0 : oe1;
            cur_miso = (sel == 0) ? miso0 : miso1;
            if (cur_oe) begin
                oe_hi++;
                if (i < 8) oe_early++;
            end else if (cur_miso) begin
                miso_bad++;
            end
            if (i >= 8 && i - 8 < dw) rx = {rx[62:0], cur_miso};
            sck = 1'b1;
            repeat (HP) @(posedge clk);
            #1 sck = 1'b0;
        end
        repeat (HP) @(posedge clk);
        #1;
        if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ws_n2 = (sel == 0) ? ws0 : ws1;
        fe_n2 = (sel == 0) ? fe0 : fe1;
        @(posedge clk);
        #1;
        ws_n3 = (sel == 0) ? ws0 : ws1;
        fe_n3 = (sel == 0) ? fe0 : fe1;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        logic [63:0] rx;
        int oe_hi, oe_early, miso_bad;
        logic ws2, ws3, fe2, fe3;

        for (int k = 0; k < 4; k++) exp0[k] = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        check_regs0("reset");
        chk("reset_outs0", {59'h0, oe0, miso0, ws0, fe0, wa0 != 2'd0}, 64'h0);
        chk("reset_outs1", {59'h0, oe1, miso1, ws1, fe1, wa1 != 3'd0}, 64'h0);
        chk("reset_rstval1", {48'h0, regs1[3*16 +: 16]}, 64'hA5A5);
        resetn = 1'b1;
        repeat (4) @(posedge clk);

        // Write 0xDEADBEEF to register 1, checking the N+3 commit latency
        sb_a0.push_back(1); sb_d0.push_back(64'hDEADBEEF); exp0[1] = 32'hDEADBEEF;
        spi_frame(0, 8'h81, 64'hDEADBEEF, 32, 40, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("w1_strobe_n2", {63'h0, ws2}, 64'h0);
        chk("w1_strobe_n3", {63'h0, ws3}, 64'h1);
        chk("w1_no_err", {62'h0, fe2, fe3}, 64'h0);
        chk("w1_oe_count", 64'(oe_hi), 64'h0);
        chk("w1_ws_count", 64'(ws_cnt0), 64'h1);
        chk("w1_addr_held", {62'h0, wa0}, 64'h1);
        check_regs0("w1");

        // Read it back
        spi_frame(0, 8'h01, 64'h0, 32, 40, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("r1_data", rx, 64'hDEADBEEF);
        chk("r1_oe_count", 64'(oe_hi), 64'd32);
        chk("r1_oe_early", 64'(oe_early), 64'h0);
        chk("r1_miso_quiet", 64'(miso_bad), 64'h0);
        chk("r1_no_pulse", {62'h0, ws3, fe3}, 64'h0);
        chk("r1_oe_off", {62'h0, oe0, miso0}, 64'h0);
        chk("r1_ws_count", 64'(ws_cnt0), 64'h1);
        check_regs0("r1");

        // Don't-care command bits set, address 0
        sb_a0.push_back(0); sb_d0.push_back(64'h0F0F1234); exp0[0] = 32'h0F0F1234;
        spi_frame(0, 8'hFC, 64'h0F0F1234, 32, 40, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("w0_strobe_n3", {63'h0, ws3}, 64'h1);
        check_regs0("w0");
        spi_frame(0, 8'h02, 64'hFFFFFFFF, 32, 40, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("r2_unwritten", rx, 64'h0);

        // Short and long write frames
        spi_frame(0, 8'h83, 64'h12345678, 32, 39, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("short_err_n2", {63'h0, fe2}, 64'h0);
        chk("short_err_n3", {63'h0, fe3}, 64'h1);
        chk("short_no_wr", {63'h0, ws3}, 64'h0);
        spi_frame(0, 8'h83, 64'h12345678, 32, 41, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("long_err_n3", {63'h0, fe3}, 64'h1);
        chk("long_no_wr", {63'h0, ws3}, 64'h0);
        chk("bad_err_count", 64'(fe_cnt0), 64'h2);
        check_regs0("bad");

        // Reset mid-frame, then a clean write to the same address
        spi_frame(0, 8'h82, 64'h55AA55AA, 32, 40, 20, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("abort_no_pulse", {62'h0, ws3, fe3}, 64'h0);
        chk("abort_counts", {ws_cnt0[31:0], fe_cnt0[31:0]}, {32'd2, 32'd2});
        check_regs0("abort");
        sb_a0.push_back(2); sb_d0.push_back(64'hCAFEF00D); exp0[2] = 32'hCAFEF00D;
        spi_frame(0, 8'h82, 64'hCAFEF00D, 32, 40, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("w2_strobe_n3", {63'h0, ws3}, 64'h1);
        check_regs0("w2");

        // Second configuration: 8 x 16-bit registers
        sb_a1.push_back(5); sb_d1.push_back(64'h1234);
        spi_frame(1, 8'h85, 64'h1234, 16, 24, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("d1_w5_strobe", {63'h0, ws3}, 64'h1);
        chk("d1_reg5", {48'h0, regs1[5*16 +: 16]}, 64'h1234);
        chk("d1_reg4", {48'h0, regs1[4*16 +: 16]}, 64'hA5A5);
        spi_frame(1, 8'h05, 64'h0, 16, 24, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("d1_r5_data", rx, 64'h1234);
        chk("d1_r5_oe", 64'(oe_hi), 64'd16);
        spi_frame(1, 8'h03, 64'h0, 16, 24, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("d1_r3_rstval", rx, 64'hA5A5);
        spi_frame(1, 8'h00, 64'h0, 16, 0, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("d1_empty_cs", {62'h0, ws3, fe3}, 64'h0);
        spi_frame(0, 8'h00, 64'h0, 32, 0, -1, rx, oe_hi, oe_early, miso_bad, ws2, ws3, fe2, fe3);
        chk("d0_empty_cs", {62'h0, ws3, fe3}, 64'h0);
        chk("final_counts", {ws_cnt0[15:0], fe_cnt0[15:0], ws_cnt1[15:0], fe_cnt1[15:0]},
            {16'd3, 16'd2, 16'd1, 16'd0});
        chk("sb_drained", 64'(sb_a0.size() + sb_a1.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
